// File: rtl/decode_ctrl_if.sv
// ID-stage instruction fields in, registered E-stage control bundle and hazard controls out.
interface decode_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5
);
  logic [6:0]            opcD;
  logic [2:0]            func3D;
  logic [6:0]            func7D;
  logic [REG_ADDR_W-1:0] rs1D;
  logic [REG_ADDR_W-1:0] rs2D;
  logic [REG_ADDR_W-1:0] rdE;
  logic                  PCSrcE;

  logic [2:0]            ImmSrcD;
  logic                  RegWriteE;
  logic                  MemWriteE;
  logic                  ALUSrcE;
  logic                  luiE;
  logic                  MulE;
  logic                  IllegalE;
  logic [1:0]            ResultSrcE;
  logic [1:0]            ALU_opcE;
  logic [1:0]            JumpE;
  logic [2:0]            BranchE;
  logic                  StallF;
  logic                  StallD;
  logic                  StallE;
  logic                  FlushD;
  logic                  FlushE;

  modport master (
    output opcD, func3D, func7D, rs1D, rs2D, rdE, PCSrcE,
    input  ImmSrcD, RegWriteE, MemWriteE, ALUSrcE, luiE, MulE, IllegalE,
           ResultSrcE, ALU_opcE, JumpE, BranchE,
           StallF, StallD, StallE, FlushD, FlushE
  );

  modport slave (
    input  opcD, func3D, func7D, rs1D, rs2D, rdE, PCSrcE,
    output ImmSrcD, RegWriteE, MemWriteE, ALUSrcE, luiE, MulE, IllegalE,
           ResultSrcE, ALU_opcE, JumpE, BranchE,
           StallF, StallD, StallE, FlushD, FlushE
  );
endinterface

// File: rtl/decode_ctrl_stage.sv
// RV32 decode-stage controller: decodes into an ID/EX control register and
// produces load-use stall, branch flush and M-op busy-window stalls.
module decode_ctrl_stage #(
  parameter bit          ENABLE_M    = 1'b1,
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned REG_ADDR_W  = 5
) (
  input logic          clk,
  input logic          rst,
  decode_ctrl_if.slave bus
);

  localparam int unsigned      CNT_W     = $clog2(MUL_LATENCY) + 1;
  localparam bit               MUL_MULTI = (MUL_LATENCY > 1);
  localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_LATENCY - 1);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       lui;
    logic       mul;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_opc;
    logic [1:0] jump;
    logic [2:0] branch;
  } ctrl_t;

  ctrl_t            ctrl_d;
  ctrl_t            ctrl_e;
  logic [2:0]       imm_src_d;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             lw_stall;
  logic             stall_e;
  logic             flush_e;

  // Opcode/func decode into the D-stage control bundle; anything unlisted is illegal.
  always_comb begin
    ctrl_d    = '0;
    imm_src_d = 3'b000;
    case (bus.opcD)
      OP_R: begin
        case (bus.func7D)
          7'b0000000, 7'b0100000: begin
            ctrl_d.alu_opc   = 2'b10;
            ctrl_d.reg_write = 1'b1;
          end
          7'b0000001: begin
            if (ENABLE_M) begin
              ctrl_d.alu_opc   = 2'b10;
              ctrl_d.reg_write = 1'b1;
              ctrl_d.mul       = 1'b1;
            end else begin
              ctrl_d.illegal = 1'b1;
            end
          end
          default: ctrl_d.illegal = 1'b1;
        endcase
      end
      OP_I: begin
        ctrl_d.alu_opc   = 2'b11;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      OP_S: begin
        imm_src_d        = 3'b001;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      OP_B: begin
        ctrl_d.alu_opc = 2'b01;
        imm_src_d      = 3'b010;
        case (bus.func3D)
          3'b000:  ctrl_d.branch = 3'b001;
          3'b001:  ctrl_d.branch = 3'b010;
          3'b100:  ctrl_d.branch = 3'b011;
          3'b101:  ctrl_d.branch = 3'b100;
          default: ctrl_d.illegal = 1'b1;
        endcase
      end
      OP_JALR: begin
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.jump       = 2'b10;
        ctrl_d.result_src = 2'b10;
      end
      OP_LW: begin
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = 2'b01;
      end
      OP_JAL: begin
        imm_src_d         = 3'b011;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.jump       = 2'b01;
        ctrl_d.result_src = 2'b10;
      end
      OP_LUI: begin
        imm_src_d         = 3'b100;
        ctrl_d.result_src = 2'b11;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.lui        = 1'b1;
      end
      default: ctrl_d.illegal = 1'b1;
    endcase
  end

  // Hazard detection: busy window dominates, so load-use and flush wait until it drops.
  assign busy     = (cnt != '0);
  assign lw_stall = (ctrl_e.result_src == 2'b01) && ctrl_e.reg_write && (bus.rdE != '0) &&
                    ((bus.rdE == bus.rs1D) || (bus.rdE == bus.rs2D));
  assign stall_e  = busy;
  assign flush_e  = (bus.PCSrcE || lw_stall) && !busy;

  // ID/EX control register: reset, hold, bubble, or load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_e <= '0;
    end else if (stall_e) begin
      ctrl_e <= ctrl_e;
    end else if (flush_e) begin
      ctrl_e <= '0;
    end else begin
      ctrl_e <= ctrl_d;
    end
  end

  // Busy window: an M-op entering E occupies the remaining MUL_LATENCY-1 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (MUL_MULTI && !stall_e && !flush_e && ctrl_d.mul) begin
      cnt <= MUL_LOAD;
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Output mapping.
  assign bus.ImmSrcD    = imm_src_d;
  assign bus.RegWriteE  = ctrl_e.reg_write;
  assign bus.MemWriteE  = ctrl_e.mem_write;
  assign bus.ALUSrcE    = ctrl_e.alu_src;
  assign bus.luiE       = ctrl_e.lui;
  assign bus.MulE       = ctrl_e.mul;
  assign bus.IllegalE   = ctrl_e.illegal;
  assign bus.ResultSrcE = ctrl_e.result_src;
  assign bus.ALU_opcE   = ctrl_e.alu_opc;
  assign bus.JumpE      = ctrl_e.jump;
  assign bus.BranchE    = ctrl_e.branch;
  assign bus.StallF     = busy | lw_stall;
  assign bus.StallD     = busy | lw_stall;
  assign bus.StallE     = stall_e;
  assign bus.FlushD     = bus.PCSrcE & ~busy;
  assign bus.FlushE     = flush_e;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: three configurations (M, no-M, single-cycle M)
// driven with shared stimulus; directed scenarios plus a randomized model run.
module tb_decode_ctrl_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rs1, rs2, rde;
  logic       pcsrc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_ctrl_if #(.REG_ADDR_W(5)) bus0 ();
  decode_ctrl_if #(.REG_ADDR_W(5)) bus1 ();
  decode_ctrl_if #(.REG_ADDR_W(5)) bus2 ();

  decode_ctrl_stage #(.ENABLE_M(1'b1), .MUL_LATENCY(3), .REG_ADDR_W(5)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  decode_ctrl_stage #(.ENABLE_M(1'b0), .MUL_LATENCY(3), .REG_ADDR_W(5)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  decode_ctrl_stage #(.ENABLE_M(1'b1), .MUL_LATENCY(1), .REG_ADDR_W(5)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.opcD = opc;  assign bus1.opcD = opc;  assign bus2.opcD = opc;
  assign bus0.func3D = f3; assign bus1.func3D = f3; assign bus2.func3D = f3;
  assign bus0.func7D = f7; assign bus1.func7D = f7; assign bus2.func7D = f7;
  assign bus0.rs1D = rs1;  assign bus1.rs1D = rs1;  assign bus2.rs1D = rs1;
  assign bus0.rs2D = rs2;  assign bus1.rs2D = rs2;  assign bus2.rs2D = rs2;
  assign bus0.rdE = rde;   assign bus1.rdE = rde;   assign bus2.rdE = rde;
  assign bus0.PCSrcE = pcsrc; assign bus1.PCSrcE = pcsrc; assign bus2.PCSrcE = pcsrc;

  // E bundle layout: rw mw as lui mul ill rs[2] ao[2] j[2] br[3]
  logic [14:0] e_act [3];
  logic [4:0]  s_act [3];   // StallF StallD StallE FlushD FlushE
  logic [2:0]  imm_act [3];

  assign e_act[0] = {bus0.RegWriteE, bus0.MemWriteE, bus0.ALUSrcE, bus0.luiE, bus0.MulE, bus0.IllegalE,
                     bus0.ResultSrcE, bus0.ALU_opcE, bus0.JumpE, bus0.BranchE};
  assign e_act[1] = {bus1.RegWriteE, bus1.MemWriteE, bus1.ALUSrcE, bus1.luiE, bus1.MulE, bus1.IllegalE,
                     bus1.ResultSrcE, bus1.ALU_opcE, bus1.JumpE, bus1.BranchE};
  assign e_act[2] = {bus2.RegWriteE, bus2.MemWriteE, bus2.ALUSrcE, bus2.luiE, bus2.MulE, bus2.IllegalE,
                     bus2.ResultSrcE, bus2.ALU_opcE, bus2.JumpE, bus2.BranchE};
  assign s_act[0] = {bus0.StallF, bus0.StallD, bus0.StallE, bus0.FlushD, bus0.FlushE};
  assign s_act[1] = {bus1.StallF, bus1.StallD, bus1.StallE, bus1.FlushD, bus1.FlushE};
  assign s_act[2] = {bus2.StallF, bus2.StallD, bus2.StallE, bus2.FlushD, bus2.FlushE};
  assign imm_act[0] = bus0.ImmSrcD;
  assign imm_act[1] = bus1.ImmSrcD;
  assign imm_act[2] = bus2.ImmSrcD;

  localparam logic [14:0] F_RW  = 15'd1 << 14;
  localparam logic [14:0] F_MW  = 15'd1 << 13;
  localparam logic [14:0] F_AS  = 15'd1 << 12;
  localparam logic [14:0] F_LUI = 15'd1 << 11;
  localparam logic [14:0] F_MUL = 15'd1 << 10;
  localparam logic [14:0] F_ILL = 15'd1 << 9;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_S = 7'b0100011, OP_B = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LW = 7'b0000011, OP_JAL = 7'b1101111, OP_LUI = 7'b0110111;

  function automatic logic [14:0] rs_f(input logic [1:0] v); return {6'b0, v, 7'b0}; endfunction
  function automatic logic [14:0] ao_f(input logic [1:0] v); return {8'b0, v, 5'b0}; endfunction
  function automatic logic [14:0] j_f(input logic [1:0] v);  return {10'b0, v, 3'b0}; endfunction
  function automatic logic [14:0] br_f(input logic [2:0] v); return {12'b0, v}; endfunction

  // Reference decode table.
  function automatic logic [14:0] dec(input logic [6:0] o, input logic [2:0] fn3, input logic [6:0] fn7, input bit en_m);
    case (o)
      OP_R: begin
        if (fn7 == 7'h00 || fn7 == 7'h20) return F_RW | ao_f(2'b10);
        if (fn7 == 7'h01 && en_m)         return F_RW | F_MUL | ao_f(2'b10);
        return F_ILL;
      end
      OP_I:    return F_RW | F_AS | ao_f(2'b11);
      OP_S:    return F_AS | F_MW;
      OP_B: begin
        case (fn3)
          3'd0:    return ao_f(2'b01) | br_f(3'b001);
          3'd1:    return ao_f(2'b01) | br_f(3'b010);
          3'd4:    return ao_f(2'b01) | br_f(3'b011);
          3'd5:    return ao_f(2'b01) | br_f(3'b100);
          default: return ao_f(2'b01) | F_ILL;
        endcase
      end
      OP_JALR: return F_AS | F_RW | j_f(2'b10) | rs_f(2'b10);
      OP_LW:   return F_AS | F_RW | rs_f(2'b01);
      OP_JAL:  return F_RW | j_f(2'b01) | rs_f(2'b10);
      OP_LUI:  return F_RW | F_LUI | rs_f(2'b11);
      default: return F_ILL;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      OP_S:    return 3'b001;
      OP_B:    return 3'b010;
      OP_JAL:  return 3'b011;
      OP_LUI:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] fn3, input logic [6:0] fn7);
    opc = o; f3 = fn3; f7 = fn7;
  endtask

  task automatic test_reset();
    rst = 1'b1; set_instr(7'h00, 3'd0, 7'd0);
    rs1 = '0; rs2 = '0; rde = '0; pcsrc = 1'b0;
    cycle(); cycle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (e_act[k] !== 15'd0 || s_act[k] !== 5'd0) begin
        failures++;
        $display("FAIL reset dut%0d: e=%h s=%b, required e=0 s=0", k, e_act[k], s_act[k]);
      end
    end
  endtask

  task automatic test_lw();
    rst = 1'b0; set_instr(OP_LW, 3'b010, 7'd0);
    #1;
    checks++;
    if (imm_act[0] !== 3'b000 || s_act[0] !== 5'd0) begin
      failures++;
      $display("FAIL lw_comb: imm=%b s=%b, required imm=000 s=00000", imm_act[0], s_act[0]);
    end
    cycle();
    checks++;
    if (e_act[0] !== (F_RW | F_AS | rs_f(2'b01)) || s_act[0] !== 5'd0) begin
      failures++;
      $display("FAIL lw_e: e=%h s=%b, required e=%h s=00000", e_act[0], s_act[0], F_RW | F_AS | rs_f(2'b01));
    end
  endtask

  task automatic test_load_use();
    set_instr(OP_R, 3'd0, 7'd0); rs1 = 5'd5; rs2 = 5'd0; rde = 5'd5;
    #1;
    checks++;
    if (s_act[0] !== 5'b11001) begin
      failures++;
      $display("FAIL load_use_stall: s=%b, required 11001", s_act[0]);
    end
    cycle();
    checks++;
    if (e_act[0] !== 15'd0 || s_act[0] !== 5'd0) begin
      failures++;
      $display("FAIL load_use_bubble: e=%h s=%b, required e=0 s=00000", e_act[0], s_act[0]);
    end
    cycle();
    checks++;
    if (e_act[0] !== (F_RW | ao_f(2'b10))) begin
      failures++;
      $display("FAIL load_use_add: e=%h, required %h", e_act[0], F_RW | ao_f(2'b10));
    end
    rs1 = '0; rde = '0;
  endtask

  task automatic test_mul();
    set_instr(OP_R, 3'd0, 7'h01);
    cycle();
    checks++;
    if (e_act[0] !== (F_RW | F_MUL | ao_f(2'b10)) || s_act[0] !== 5'b11100) begin
      failures++;
      $display("FAIL mul_enter: e=%h s=%b, required e=%h s=11100", e_act[0], s_act[0], F_RW | F_MUL | ao_f(2'b10));
    end
    checks++;
    if (e_act[1] !== F_ILL || s_act[1] !== 5'd0) begin
      failures++;
      $display("FAIL mul_disabled: e=%h s=%b, required e=%h s=00000", e_act[1], s_act[1], F_ILL);
    end
    checks++;
    if (e_act[2] !== (F_RW | F_MUL | ao_f(2'b10)) || s_act[2] !== 5'd0) begin
      failures++;
      $display("FAIL mul_lat1: e=%h s=%b, required e=%h s=00000", e_act[2], s_act[2], F_RW | F_MUL | ao_f(2'b10));
    end
    set_instr(OP_I, 3'd0, 7'd0);
    cycle();
    checks++;
    if (e_act[0] !== (F_RW | F_MUL | ao_f(2'b10)) || s_act[0] !== 5'b11100) begin
      failures++;
      $display("FAIL mul_hold: e=%h s=%b, required held mul s=11100", e_act[0], s_act[0]);
    end
    checks++;
    if (e_act[2] !== (F_RW | F_AS | ao_f(2'b11))) begin
      failures++;
      $display("FAIL mul_lat1_next: e=%h, required %h", e_act[2], F_RW | F_AS | ao_f(2'b11));
    end
    cycle();
    checks++;
    if (e_act[0] !== (F_RW | F_MUL | ao_f(2'b10)) || s_act[0] !== 5'd0) begin
      failures++;
      $display("FAIL mul_release: e=%h s=%b, required held mul s=00000", e_act[0], s_act[0]);
    end
    cycle();
    checks++;
    if (e_act[0] !== (F_RW | F_AS | ao_f(2'b11))) begin
      failures++;
      $display("FAIL mul_next: e=%h, required %h", e_act[0], F_RW | F_AS | ao_f(2'b11));
    end
  endtask

  task automatic test_back_to_back();
    set_instr(OP_R, 3'd0, 7'h01);
    cycle();
    set_instr(OP_R, 3'd1, 7'h01);
    cycle(); cycle();
    checks++;
    if (s_act[0] !== 5'd0 || e_act[0] !== (F_RW | F_MUL | ao_f(2'b10))) begin
      failures++;
      $display("FAIL b2b_gap: e=%h s=%b, required first mul s=00000", e_act[0], s_act[0]);
    end
    cycle();
    checks++;
    if (s_act[0] !== 5'b11100 || e_act[0] !== (F_RW | F_MUL | ao_f(2'b10))) begin
      failures++;
      $display("FAIL b2b_reload: e=%h s=%b, required second mul s=11100", e_act[0], s_act[0]);
    end
    set_instr(OP_I, 3'd0, 7'd0);
    cycle(); cycle(); cycle();
  endtask

  task automatic test_branch_flush();
    set_instr(OP_B, 3'd0, 7'd0);
    #1;
    checks++;
    if (imm_act[0] !== 3'b010) begin
      failures++;
      $display("FAIL beq_imm: imm=%b, required 010", imm_act[0]);
    end
    cycle();
    checks++;
    if (e_act[0] !== (ao_f(2'b01) | br_f(3'b001))) begin
      failures++;
      $display("FAIL beq_e: e=%h, required %h", e_act[0], ao_f(2'b01) | br_f(3'b001));
    end
    pcsrc = 1'b1; set_instr(OP_I, 3'd0, 7'd0);
    #1;
    checks++;
    if (s_act[0] !== 5'b00011) begin
      failures++;
      $display("FAIL taken_flush: s=%b, required 00011", s_act[0]);
    end
    cycle();
    checks++;
    if (e_act[0] !== 15'd0) begin
      failures++;
      $display("FAIL taken_bubble: e=%h, required 0", e_act[0]);
    end
    pcsrc = 1'b0;
  endtask

  task automatic test_illegal_and_rd0();
    set_instr(7'b1111111, 3'd7, 7'h7f);
    cycle();
    checks++;
    if (e_act[0] !== F_ILL) begin
      failures++;
      $display("FAIL illegal_op: e=%h, required %h", e_act[0], F_ILL);
    end
    set_instr(OP_LW, 3'b010, 7'd0);
    cycle();
    set_instr(OP_S, 3'b010, 7'd0); rs1 = '0; rs2 = '0; rde = '0;
    #1;
    checks++;
    if (s_act[0] !== 5'd0) begin
      failures++;
      $display("FAIL rd0_no_stall: s=%b, required 00000", s_act[0]);
    end
    rs2 = 5'd3; rde = 5'd3;
    #1;
    checks++;
    if (s_act[0] !== 5'b11001) begin
      failures++;
      $display("FAIL rs2_stall: s=%b, required 11001", s_act[0]);
    end
    rs2 = '0; rde = '0;
    cycle();
  endtask

  task automatic test_reset_during_busy();
    set_instr(OP_R, 3'd0, 7'h01);
    cycle();
    set_instr(OP_I, 3'd0, 7'd0);
    cycle();
    checks++;
    if (s_act[0] !== 5'b11100) begin
      failures++;
      $display("FAIL rst_busy_pre: s=%b, required 11100", s_act[0]);
    end
    rst = 1'b1;
    cycle();
    checks++;
    if (e_act[0] !== 15'd0 || s_act[0] !== 5'd0) begin
      failures++;
      $display("FAIL rst_busy_clear: e=%h s=%b, required e=0 s=00000", e_act[0], s_act[0]);
    end
    rst = 1'b0; set_instr(OP_LUI, 3'd0, 7'd0);
    cycle();
    checks++;
    if (e_act[0] !== (F_RW | F_LUI | rs_f(2'b11)) || s_act[0] !== 5'd0) begin
      failures++;
      $display("FAIL rst_busy_lui: e=%h s=%b, required e=%h s=00000", e_act[0], s_act[0], F_RW | F_LUI | rs_f(2'b11));
    end
  endtask

  function automatic logic [6:0] pick_op(input int unsigned n);
    case (n)
      0: return OP_R;    1: return OP_I;   2: return OP_S;   3: return OP_B;
      4: return OP_JALR; 5: return OP_LW;  6: return OP_JAL; 7: return OP_LUI;
      8: return OP_LW;   default: return 7'($urandom);
    endcase
  endfunction

  function automatic logic [6:0] pick_f7(input int unsigned n);
    case (n)
      0: return 7'h00; 1: return 7'h20; 2: return 7'h01; 3: return 7'h01;
      default: return 7'($urandom);
    endcase
  endfunction

  // Cycle model per configuration: the E bundle and the count of busy cycles still owed.
  task automatic test_random();
    logic [14:0] m_e [3];
    int          m_left [3];
    bit          en_m [3];
    int          lat [3];
    logic [4:0]  exp_s;
    bit          lw, bsy;
    en_m[0] = 1'b1; en_m[1] = 1'b0; en_m[2] = 1'b1;
    lat[0] = 3; lat[1] = 3; lat[2] = 1;
    rst = 1'b1; pcsrc = 1'b0;
    cycle();
    for (int k = 0; k < 3; k++) begin
      m_e[k] = '0; m_left[k] = 0;
    end
    for (int i = 0; i < 2000; i++) begin
      rst   = ($urandom_range(0, 63) == 0);
      opc   = pick_op($urandom_range(0, 9));
      f3    = 3'($urandom_range(0, 7));
      f7    = pick_f7($urandom_range(0, 4));
      rs1   = 5'($urandom_range(0, 3));
      rs2   = 5'($urandom_range(0, 3));
      rde   = 5'($urandom_range(0, 3));
      pcsrc = ($urandom_range(0, 7) == 0);
      #1;
      for (int k = 0; k < 3; k++) begin
        lw    = (m_e[k][8:7] == 2'b01) && m_e[k][14] && (rde != 0) && (rde == rs1 || rde == rs2);
        bsy   = (m_left[k] > 0);
        exp_s = {bsy | lw, bsy | lw, bsy, pcsrc & !bsy, (pcsrc | lw) & !bsy};
        checks++;
        if (e_act[k] !== m_e[k] || s_act[k] !== exp_s || imm_act[k] !== imm_of(opc)) begin
          failures++;
          $display("FAIL random dut%0d iter %0d: e=%h s=%b imm=%b, required e=%h s=%b imm=%b",
                   k, i, e_act[k], s_act[k], imm_act[k], m_e[k], exp_s, imm_of(opc));
        end
      end
      cycle();
      for (int k = 0; k < 3; k++) begin
        lw  = (m_e[k][8:7] == 2'b01) && m_e[k][14] && (rde != 0) && (rde == rs1 || rde == rs2);
        bsy = (m_left[k] > 0);
        if (rst) begin
          m_e[k] = '0; m_left[k] = 0;
        end else if (bsy) begin
          m_left[k] = m_left[k] - 1;
        end else if (pcsrc || lw) begin
          m_e[k] = '0;
        end else begin
          m_e[k] = dec(opc, f3, f7, en_m[k]);
          if (m_e[k][10]) m_left[k] = lat[k] - 1;
        end
      end
    end
    rst = 1'b0; pcsrc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_use();
    test_mul();
    test_back_to_back();
    test_branch_flush();
    test_illegal_and_rd0();
    test_reset_during_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
